division_unit: RTL
==================

Name: division_unit

Overview:
- Sequential restoring shift-subtract divider.
- Inverse companion of the shift-add multiplication unit in the redundancy datapath, with the same enable/valid hold handshake.
- Takes a WORD_WIDTH dividend and divisor and produces a truncated quotient, a full-width remainder, an overflow flag and a divide-by-zero flag.
- One quotient bit per two-cycle iteration, so latency is fixed.

Parameters:
- WORD_WIDTH, 8, bitwidth of dividend, divisor, remainder and internal quotient.
- QUOT_WIDTH, 7, bitwidth of the quotient output; must be 1..WORD_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  request; level-held by the requester until the result is consumed.
- dividend  input  WORD_WIDTH  numerator; sampled only at acceptance.
- divisor  input  WORD_WIDTH  denominator; sampled only at acceptance.
- valid  output  1  result outputs are meaningful.
- overflow  output  1  quotient does not fit in QUOT_WIDTH bits.
- div_by_zero  output  1  the accepted divisor was 0.
- quotient  output  QUOT_WIDTH  quot_reg[QUOT_WIDTH-1:0].
- remainder  output  WORD_WIDTH  rem_reg[WORD_WIDTH-1:0].

Behaviour:
- Reset (async, any state, including mid-operation):
  - state to DIV_IDLE.
  - quot_reg, rem_reg (WORD_WIDTH+1 bits), divisor_reg, counter, valid and div_by_zero_reg all cleared.
  - Every output is 0 during reset.
- Registers: quot_reg is WORD_WIDTH bits. counter is $clog2(WORD_WIDTH+1) bits. rem_reg carries one guard bit for the compare.
- DIV_IDLE, enable=1 at an edge:
  - quot_reg <= dividend; divisor_reg <= divisor; rem_reg <= 0; counter <= 0.
  - div_by_zero_reg <= (divisor==0).
  - Go to DIV_SHIFT.
- DIV_IDLE, enable=0: hold.
- DIV_SHIFT: {rem_reg, quot_reg} <= {rem_reg, quot_reg} << 1. Go to DIV_SUB.
- DIV_SUB:
  - If rem_reg >= {1'b0, divisor_reg}: rem_reg <= rem_reg - divisor_reg and quot_reg[0] <= 1. Otherwise hold both.
  - counter <= counter+1.
  - If counter == WORD_WIDTH-1: valid <= 1 and go to DIV_OUTPUT. Otherwise go to DIV_SHIFT.
- DIV_OUTPUT:
  - If enable=0 at an edge: valid <= 0 and go to DIV_IDLE.
  - Otherwise hold; valid and the result stay stable.
- Latency:
  - valid rises at the (2*WORD_WIDTH+1)th rising edge after and including the accepting edge (17 for W=8).
  - Next acceptance is possible at the edge after the return to DIV_IDLE.
- Handshake boundaries:
  - Dividend/divisor changes after acceptance are ignored.
  - enable dropping mid-computation does not abort; the operation completes.
  - If enable is already low on entering DIV_OUTPUT, valid is high for exactly one cycle.
- Divide by zero:
  - No special datapath. Natural restoring behaviour gives quot_reg all ones and remainder = dividend.
  - div_by_zero=1; overflow follows the normal rule.
  - Latency is unchanged.
- Outputs:
  - overflow = |quot_reg[WORD_WIDTH-1:QUOT_WIDTH]; constant 0 when QUOT_WIDTH == WORD_WIDTH.
  - overflow and div_by_zero are combinational from registers and only meaningful while valid=1.
- No X propagation: every register has a defined reset and update in every state.

Optional Feature:
- Macro DIVISION_UNIT_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - At acceptance, magnitudes are loaded and the sign of the dividend and the XOR sign of the operands are registered.
  - After the final DIV_SUB, one extra DIV_FIX state negates the quotient if the XOR sign is 1 and negates the remainder if the dividend sign is 1. This gives truncation toward zero.
  - valid rises one edge later (2*WORD_WIDTH+2).
  - overflow = quotient not representable as a QUOT_WIDTH-bit signed value.
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
- Undefined: unsigned only, exactly as above; DIV_FIX does not exist.

Decomposition:
- Package div_pkg holds the 2-bit state encoding (or 3-bit with the macro): DIV_IDLE, DIV_SHIFT, DIV_SUB, DIV_OUTPUT, DIV_FIX.
- The package also holds the counter-width function.
- One natural sub-module, div_restore_step: combinational compare/subtract producing next rem_reg and the quotient bit. Reusable by a future pipelined divider.

Test Plan:
- Unsigned division: 100/7 (W=8, Q=7), enable held -> valid at edge 17, quotient 14, remainder 2, overflow 0, div_by_zero 0. valid holds until enable drops, then 0 on the next edge.
- Quotient overflow: 200/1 -> quotient 72 (200 mod 128), remainder 0, overflow 1.
- Divide by zero: 5/0 -> quotient 127, remainder 5, overflow 1, div_by_zero 1; latency still 17.
- Small over large: 3/9 -> quotient 0, remainder 3. Also pulse enable for 1 cycle -> valid high exactly one cycle.
- Reset mid-operation: reset_n low at edge 6 of 100/7 -> all outputs 0 immediately. After release, a 50/5 request gives quotient 10, remainder 0 at edge 17.
- Signed, with DIVISION_UNIT_SIGNED_EN: -100/7 -> quotient -14, remainder -2, valid at edge 18. 100/-7 -> quotient -14, remainder 2.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: state encoding and sizing helper shared by the restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a. DIVISION_UNIT_SIGNED_EN adds the DIV_FIX state, which widens the state to 3 bits.
package div_pkg;

`ifdef DIVISION_UNIT_SIGNED_EN
    typedef enum logic [2:0] {
        DIV_IDLE   = 3'd0,
        DIV_SHIFT  = 3'd1,
        DIV_SUB    = 3'd2,
        DIV_OUTPUT = 3'd3,
        DIV_FIX    = 3'd4
    } div_state_e;
`else
    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_SHIFT  = 2'd1,
        DIV_SUB    = 2'd2,
        DIV_OUTPUT = 2'd3
    } div_state_e;
`endif

    // The iteration counter must be able to hold the value WORD_WIDTH.
    function automatic int div_cnt_width(input int word_width);
        return $clog2(word_width + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring compare/subtract.
// Latency: combinational. Backpressure: none.
// Ports: rem_i is the partial remainder with a guard bit, and divisor_i is the divisor.
// rem_o is the next remainder, and q_bit_o is the produced quotient bit.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] divisor_ext;
    logic [WIDTH:0] diff;

    assign divisor_ext = {1'b0, divisor_i};
    assign diff        = rem_i - divisor_ext;
    assign q_bit_o     = (rem_i >= divisor_ext);
    assign rem_o       = q_bit_o ? diff : rem_i;

endmodule

// File: rtl/division_unit.sv
// division_unit: a sequential restoring shift-subtract divider.
// Latency: valid rises 2*WORD_WIDTH+1 edges after acceptance, counting the accept edge.
//          With DIVISION_UNIT_SIGNED_EN defined, valid rises 2*WORD_WIDTH+2 edges after acceptance.
// Backpressure: the requester holds enable until it consumes the result.
//               valid and the result stay stable until enable drops.
// Ports: clk and reset_n (asynchronous, active low).
//        Request side: enable, dividend, divisor. The operands are sampled only at acceptance.
//        Result side: valid, quotient, remainder, overflow, div_by_zero.
//        overflow and div_by_zero are meaningful only while valid is high.
module division_unit
    import div_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int QUOT_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic                  valid,
    output logic                  overflow,
    output logic                  div_by_zero,
    output logic [QUOT_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = div_cnt_width(WORD_WIDTH);

    div_state_e      state_q, state_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            dbz_q, dbz_d;
    logic [W:0]      step_rem;
    logic            step_qbit;
`ifdef DIVISION_UNIT_SIGNED_EN
    logic            qneg_q, qneg_d;   // negate quotient in DIV_FIX
    logic            rneg_q, rneg_d;   // negate remainder (dividend sign)
`endif

    div_restore_step #(.WIDTH(W)) u_step (
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        dbz_d     = dbz_q;
`ifdef DIVISION_UNIT_SIGNED_EN
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            DIV_IDLE: begin
                if (enable) begin
`ifdef DIVISION_UNIT_SIGNED_EN
                    quot_d    = dividend[W-1] ? -dividend : dividend;
                    divisor_d = divisor[W-1]  ? -divisor  : divisor;
                    // A zero divisor keeps the all-ones quotient un-negated, so the quotient reads as -1.
                    qneg_d    = (dividend[W-1] ^ divisor[W-1]) & (divisor != '0);
                    rneg_d    = dividend[W-1];
`else
                    quot_d    = dividend;
                    divisor_d = divisor;
`endif
                    rem_d     = '0;
                    cnt_d     = '0;
                    dbz_d     = (divisor == '0);
                    state_d   = DIV_SHIFT;
                end
            end
            DIV_SHIFT: begin
                {rem_d, quot_d} = {rem_q, quot_q} << 1;
                state_d         = DIV_SUB;
            end
            DIV_SUB: begin
                rem_d     = step_rem;
                quot_d[0] = step_qbit;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
`ifdef DIVISION_UNIT_SIGNED_EN
                    state_d = DIV_FIX;
`else
                    valid_d = 1'b1;
                    state_d = DIV_OUTPUT;
`endif
                end else begin
                    state_d = DIV_SHIFT;
                end
            end
`ifdef DIVISION_UNIT_SIGNED_EN
            DIV_FIX: begin
                quot_d  = qneg_q ? -quot_q : quot_q;
                rem_d   = rneg_q ? -rem_q  : rem_q;
                valid_d = 1'b1;
                state_d = DIV_OUTPUT;
            end
`endif
            DIV_OUTPUT: begin
                if (!enable) begin
                    valid_d = 1'b0;
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DIV_IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef DIVISION_UNIT_SIGNED_EN
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            dbz_q     <= dbz_d;
`ifdef DIVISION_UNIT_SIGNED_EN
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

`ifdef DIVISION_UNIT_SIGNED_EN
    // The quotient fits as a signed QUOT_WIDTH value only when every bit from QUOT_WIDTH-1 upward matches the true result sign.
    // The true result sign is taken from the registered signs, not from quot_q, because a +2^(W-1) magnitude looks negative.
    logic q_sign;
    assign q_sign   = (qneg_q | dbz_q) & (|quot_q);
    assign overflow = (quot_q[W-1:QUOT_WIDTH-1] != {(W-QUOT_WIDTH+1){q_sign}});
`else
    if (QUOT_WIDTH == W) begin : g_no_ovf
        assign overflow = 1'b0;
    end else begin : g_ovf
        assign overflow = |quot_q[W-1:QUOT_WIDTH];
    end
`endif

    assign valid       = valid_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q[QUOT_WIDTH-1:0];
    assign remainder   = rem_q[W-1:0];

endmodule
